uart_loopback_tester: RTL and testbench
=======================================

Name: uart_loopback_tester

Overview:
- Stimulus/checker at the far end of a UART echo link.
- Drives a byte sequence into the TX byte interface of uart_tranceiver and receives the echoed bytes from its RX byte interface.
- Compares each echo against the byte sent and reports pass/fail, error count and timeout.
- Gives on-board self-test of the 8N1 echo path without a PC.

Parameters:
NUM_BYTES, 256, bytes per test run (1..65535).
TIMEOUT_CYCLES, 50000, max clk cycles to wait for one echo (~2 frames at 9600 baud / 24.18 MHz).
SEED, 8'h00, first byte of the pattern.
ERR_W, 16, width of the error counter.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
i_start  input  1  one-cycle pulse; starts a run when not busy
o_tx_data  output  8  byte to transmit
o_tx_data_valid  output  1  o_tx_data valid; held until accepted
i_tx_ready  input  1  transmitter accepts byte when high with valid
i_rx_data  input  8  received byte
i_rx_data_valid  input  1  one-cycle strobe qualifying i_rx_data
o_busy  output  1  run in progress
o_done  output  1  run finished; level, held until next start
o_pass  output  1  valid when o_done; 1 = zero errors and no timeout
o_err_count  output  ERR_W  mismatches plus unsolicited bytes plus timeouts; saturating
o_timeout  output  1  sticky; echo wait exceeded TIMEOUT_CYCLES

Behaviour:
- Reset (async, active-high): state IDLE. All outputs 0: o_tx_data = 8'h00, o_err_count = 0.
- FSM states: IDLE, SEND, WAIT_ECHO, DONE.
- IDLE:
  - i_start -> SEND next cycle.
  - Clear byte index, o_err_count, o_timeout, o_pass.
  - Load pattern register with SEED.
  - o_busy = 1 from that cycle.
- SEND:
  - o_tx_data_valid = 1 with the current pattern byte.
  - Transfer occurs in the cycle where o_tx_data_valid and i_tx_ready are both 1.
  - Next cycle: valid = 0, expected byte latched, timeout counter cleared -> WAIT_ECHO.
  - o_tx_data is stable while valid is high.
- WAIT_ECHO:
  - Timeout counter increments every cycle.
  - On i_rx_data_valid: if i_rx_data != expected, o_err_count += 1. Then advance pattern and index.
  - If index reaches NUM_BYTES -> DONE, else -> SEND.
  - Counter reaching TIMEOUT_CYCLES-1 with no strobe: o_timeout = 1, o_err_count += 1, -> DONE (run aborted).
  - Strobe and timeout in the same cycle: the strobe wins; no timeout.
- Only one byte is outstanding at a time, so RX overrun is impossible by construction.
- i_rx_data_valid in IDLE, SEND or DONE counts as an error (unsolicited byte) while o_busy is high; it is ignored in IDLE and DONE.
- DONE:
  - o_busy = 0, o_done = 1.
  - o_pass = (o_err_count == 0) && !o_timeout, registered on DONE entry.
  - i_start -> restart as from IDLE, clearing o_done the same cycle the run begins.
- i_start while busy: ignored.
- Pattern (default): byte k = SEED + k mod 256; wraps 8'hFF -> 8'h00.
- o_err_count saturates at all ones; it never wraps.
- Reset mid-run aborts immediately. A byte already accepted by the transmitter is not tracked.
- Latency: start to first o_tx_data_valid = 1 cycle. Echo strobe to next o_tx_data_valid = 1 cycle.

Optional Feature:
- Macro UART_TESTER_LFSR_EN.
- Defined: pattern is an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, shifting once per echoed byte. It starts at SEED; SEED = 8'h00 is replaced by 8'h01 to avoid lock-up.
- Not defined: incrementing pattern as above; no LFSR logic is synthesised.

Test Plan:
- Ideal loopback model (ready always 1, echo 20 cycles after accept), NUM_BYTES=4, SEED=8'hFE -> sends FE,FF,00,01. o_done=1, o_pass=1, o_err_count=0, o_timeout=0.
- Same setup, 3rd echo corrupted to 8'h55 -> o_done=1, o_pass=0, o_err_count=1. All 4 bytes still sent.
- i_tx_ready held 0 for 10 cycles -> o_tx_data_valid held high, o_tx_data constant for all 10 cycles. Exactly one transfer when ready rises.
- TIMEOUT_CYCLES=100, echo suppressed for 2nd byte -> o_timeout=1 after 100 cycles, o_err_count=1, o_pass=0, DONE with no 3rd byte sent.
- Unsolicited i_rx_data_valid pulse during SEND -> o_err_count increments by 1. i_start pulse mid-run -> no effect on index or state.
- Assert reset in WAIT_ECHO -> all outputs 0 immediately, state IDLE. A new i_start then produces a clean run from SEED.
- With UART_TESTER_LFSR_EN, SEED=8'h00 -> first byte sent is 8'h01, and the sequence matches the reference LFSR model for 16 bytes.

Source files
------------

// File: rtl/uart_loopback_tester.sv
// uart_loopback_tester
//   Drives a byte sequence into a UART transmitter and checks each echoed
//   byte that comes back on the receiver side. One byte is outstanding at a
//   time. The run ends on the last echo or when an echo does not arrive in time.
//
// Optional feature macro: UART_TESTER_LFSR_EN
//   Defined     : pattern is an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1),
//                 seeded with SEED (8'h00 is replaced by 8'h01).
//   Not defined : pattern is SEED + k (mod 256).
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   i_start           one-cycle pulse, starts a run when not busy
//   o_tx_data         byte to transmit
//   o_tx_data_valid   o_tx_data valid, held until accepted
//   i_tx_ready        transmitter accepts when high together with valid
//   i_rx_data         received byte
//   i_rx_data_valid   one-cycle strobe qualifying i_rx_data
//   o_busy            run in progress
//   o_done            run finished, held until the next start
//   o_pass            valid with o_done: no errors and no timeout
//   o_err_count       mismatches + unsolicited bytes + timeouts, saturating
//   o_timeout         sticky, echo wait exceeded TIMEOUT_CYCLES
module uart_loopback_tester #(
  parameter int unsigned NUM_BYTES      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  SEED           = 8'h00,
  parameter int unsigned ERR_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_data_valid,
  input  logic             i_tx_ready,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_data_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_count,
  output logic             o_timeout
);

  localparam int unsigned IDX_W = 16;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

`ifdef UART_TESTER_LFSR_EN
  // An all-zero LFSR never leaves zero, so a zero seed is bumped to 1.
  localparam logic [7:0] PAT_INIT = (SEED == 8'h00) ? 8'h01 : SEED;
`else
  localparam logic [7:0] PAT_INIT = SEED;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_ECHO,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         pat_q, pat_d;
  logic [7:0]         exp_q, exp_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               timeout_q, timeout_d;
  logic               pass_q, pass_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;

  // Next pattern byte after an echo.
  function automatic logic [7:0] pat_next(input logic [7:0] p);
`ifdef UART_TESTER_LFSR_EN
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
`else
    return p + 8'h01;
`endif
  endfunction

  // Saturating error increment.
  function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] e);
    return (&e) ? e : e + ERR_W'(1);
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pat_q      <= 8'h00;
      exp_q      <= 8'h00;
      idx_q      <= '0;
      tmo_q      <= '0;
      err_q      <= '0;
      timeout_q  <= 1'b0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      exp_q      <= exp_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    exp_d      = exp_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
    pass_d     = pass_q;
    busy_d     = busy_q;
    done_d     = done_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;

    case (state_q)
      // IDLE and DONE both (re)start a run; stray strobes are ignored here.
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d    = S_SEND;
          idx_d      = '0;
          err_d      = '0;
          timeout_d  = 1'b0;
          pass_d     = 1'b0;
          pat_d      = PAT_INIT;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          tx_valid_d = 1'b1;
          tx_data_d  = PAT_INIT;
        end
      end

      S_SEND: begin
        // No byte is outstanding here, so any strobe is unsolicited.
        if (i_rx_data_valid) begin
          err_d = err_inc(err_q);
        end
        if (tx_valid_q && i_tx_ready) begin
          tx_valid_d = 1'b0;
          exp_d      = tx_data_q;
          tmo_d      = '0;
          state_d    = S_WAIT_ECHO;
        end
      end

      S_WAIT_ECHO: begin
        tmo_d = tmo_q + TMO_W'(1);
        // A strobe in the final cycle wins over the timeout.
        if (i_rx_data_valid) begin
          if (i_rx_data != exp_q) begin
            err_d = err_inc(err_q);
          end
          pat_d = pat_next(pat_q);
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0) && !timeout_q;
          end else begin
            state_d    = S_SEND;
            tx_valid_d = 1'b1;
            tx_data_d  = pat_d;
          end
        end else if (tmo_q == TMO_LAST) begin
          timeout_d = 1'b1;
          err_d     = err_inc(err_q);
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_tx_data       = tx_data_q;
  assign o_tx_data_valid = tx_valid_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_pass          = pass_q;
  assign o_err_count     = err_q;
  assign o_timeout       = timeout_q;

endmodule

// File: tb/tb_uart_loopback_tester.sv
// Bench for uart_loopback_tester: a loopback partner driven from tasks,
// with expected bytes and error counts taken from a reference pattern model.
module tb_uart_loopback_tester;

`ifdef UART_TESTER_LFSR_EN
  localparam int unsigned NB   = 16;
  localparam logic [7:0]  SEED = 8'h00;
`else
  localparam int unsigned NB   = 4;
  localparam logic [7:0]  SEED = 8'hFE;
`endif
  localparam int unsigned TMO  = 100;
  localparam int unsigned EW   = 2;
  localparam int          EMAX = (1 << EW) - 1;

  logic          clk;
  logic          reset;
  logic          i_start;
  logic [7:0]    o_tx_data;
  logic          o_tx_data_valid;
  logic          i_tx_ready;
  logic [7:0]    i_rx_data;
  logic          i_rx_data_valid;
  logic          o_busy;
  logic          o_done;
  logic          o_pass;
  logic [EW-1:0] o_err_count;
  logic          o_timeout;

  int total;
  int bad;

  uart_loopback_tester #(
    .NUM_BYTES      (NB),
    .TIMEOUT_CYCLES (TMO),
    .SEED           (SEED),
    .ERR_W          (EW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_start         (i_start),
    .o_tx_data       (o_tx_data),
    .o_tx_data_valid (o_tx_data_valid),
    .i_tx_ready      (i_tx_ready),
    .i_rx_data       (i_rx_data),
    .i_rx_data_valid (i_rx_data_valid),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_pass          (o_pass),
    .o_err_count     (o_err_count),
    .o_timeout       (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference pattern: k-th byte of a run.
  function automatic logic [7:0] model_byte(input int k);
    int s;
`ifdef UART_TESTER_LFSR_EN
    int fb;
    s = (SEED == 8'h00) ? 1 : int'(SEED);
    for (int i = 0; i < k; i++) begin
      fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
      s  = ((s << 1) | fb) & 255;
    end
`else
    s = (int'(SEED) + k) % 256;
`endif
    return 8'(s);
  endfunction

  function automatic int sat(input int n);
    return (n > EMAX) ? EMAX : n;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] d);
    i_rx_data       = d;
    i_rx_data_valid = 1'b1;
    @(negedge clk);
    i_rx_data_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (o_tx_data_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Wait for a byte, stall ready for 'stall' cycles, then accept it.
  task automatic xfer(input int stall, output logic [7:0] d, output bit got);
    d = 8'h00;
    wait_valid(got);
    if (!got) return;
    i_tx_ready = 1'b0;
    repeat (stall) @(negedge clk);
    d = o_tx_data;
    i_tx_ready = 1'b1;
    @(negedge clk);
    i_tx_ready = 1'b0;
  endtask

  task automatic echo(input logic [7:0] d, input int delay);
    repeat (delay) @(negedge clk);
    pulse_rx(d);
  endtask

  // Loopback partner for bytes k0..NB-1. bad_k = -2 corrupts every byte.
  task automatic run_model(input int k0, input bit rnd, input int bad_k,
                           output int n_err, output int seq_bad, output int n_sent);
    n_err = 0; seq_bad = 0; n_sent = 0;
    for (int k = k0; k < int'(NB); k++) begin
      logic [7:0] d;
      logic [7:0] e;
      bit got;
      bit corrupt;
      xfer(rnd ? int'($urandom_range(0, 3)) : 0, d, got);
      if (!got) break;
      n_sent++;
      if (d !== model_byte(k)) seq_bad++;
      corrupt = (k == bad_k) || (bad_k == -2) || (rnd && ($urandom_range(0, 3) == 0));
      if (k == bad_k) e = (d == 8'h55) ? 8'hAA : 8'h55;
      else if (corrupt) e = d ^ 8'($urandom_range(1, 255));
      else e = d;
      if (corrupt) n_err++;
      echo(e, rnd ? int'($urandom_range(0, 60)) : 20);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (o_tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h want=00", o_tx_data); end
    total++; if (o_tx_data_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", o_tx_data_valid); end
    total++; if ({o_busy, o_done, o_pass, o_timeout} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b want=0000", {o_busy, o_done, o_pass, o_timeout}); end
    pulse_rx(8'h12);
    total++; if (o_err_count !== EW'(0)) begin bad++; $display("FAIL idle_stray_rx err got=%0d want=0", o_err_count); end
  endtask

  task automatic test_ideal();
    int n_err, seq_bad, n_sent;
    pulse_start();
    total++; if (o_tx_data_valid !== 1'b1 || o_busy !== 1'b1) begin bad++; $display("FAIL ideal_start_latency valid=%b busy=%b want=1,1", o_tx_data_valid, o_busy); end
`ifdef UART_TESTER_LFSR_EN
    total++; if (o_tx_data !== 8'h01) begin bad++; $display("FAIL lfsr_first_byte got=%h want=01", o_tx_data); end
`else
    total++; if (o_tx_data !== 8'hFE) begin bad++; $display("FAIL ideal_first_byte got=%h want=fe", o_tx_data); end
`endif
    run_model(0, 1'b0, -1, n_err, seq_bad, n_sent);
    total++; if (seq_bad !== 0 || n_sent !== int'(NB)) begin bad++; $display("FAIL ideal_sequence bad_bytes=%0d sent=%0d want=0,%0d", seq_bad, n_sent, NB); end
    total++; if ({o_done, o_pass, o_busy, o_timeout} !== 4'b1100) begin bad++; $display("FAIL ideal_flags done,pass,busy,tmo got=%b want=1100", {o_done, o_pass, o_busy, o_timeout}); end
    total++; if (o_err_count !== EW'(0)) begin bad++; $display("FAIL ideal_err got=%0d want=0", o_err_count); end
  endtask

  task automatic test_corrupt();
    int n_err, seq_bad, n_sent;
    pulse_start();
    run_model(0, 1'b0, 2, n_err, seq_bad, n_sent);
    total++; if (seq_bad !== 0 || n_sent !== int'(NB)) begin bad++; $display("FAIL corrupt_sequence bad_bytes=%0d sent=%0d want=0,%0d", seq_bad, n_sent, NB); end
    total++; if (o_done !== 1'b1 || o_pass !== 1'b0) begin bad++; $display("FAIL corrupt_flags done=%b pass=%b want=1,0", o_done, o_pass); end
    total++; if (o_err_count !== EW'(1)) begin bad++; $display("FAIL corrupt_err got=%0d want=1", o_err_count); end
  endtask

  task automatic test_ready_stall();
    logic [7:0] d0;
    int n_err, seq_bad, n_sent;
    int unstable;
    int extra;
    pulse_start();
    i_tx_ready = 1'b0;
    d0 = model_byte(0);
    unstable = 0;
    for (int c = 0; c < 10; c++) begin
      if (o_tx_data_valid !== 1'b1 || o_tx_data !== d0) unstable++;
      @(negedge clk);
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL stall_hold unstable_cycles=%0d want=0", unstable); end
    i_tx_ready = 1'b1;
    @(negedge clk);
    i_tx_ready = 1'b0;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      if (o_tx_data_valid !== 1'b0) extra++;
      @(negedge clk);
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL stall_one_transfer valid_after=%0d want=0", extra); end
    pulse_rx(d0);
    total++; if (o_tx_data_valid !== 1'b1 || o_tx_data !== model_byte(1)) begin bad++; $display("FAIL echo_to_valid valid=%b data=%h want=1,%h", o_tx_data_valid, o_tx_data, model_byte(1)); end
    run_model(1, 1'b0, -1, n_err, seq_bad, n_sent);
    total++; if (o_done !== 1'b1 || o_pass !== 1'b1 || seq_bad !== 0) begin bad++; $display("FAIL stall_run done=%b pass=%b bad_bytes=%0d want=1,1,0", o_done, o_pass, seq_bad); end
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    bit got;
    int sent3;
    pulse_start();
    xfer(0, d, got);
    echo(d, TMO - 1);
    total++; if (o_timeout !== 1'b0 || o_tx_data_valid !== 1'b1) begin bad++; $display("FAIL strobe_wins tmo=%b valid=%b want=0,1", o_timeout, o_tx_data_valid); end
    xfer(0, d, got);
    total++; if (got !== 1'b1 || d !== model_byte(1)) begin bad++; $display("FAIL tmo_second_byte got=%b data=%h want=1,%h", got, d, model_byte(1)); end
    repeat (TMO - 1) @(negedge clk);
    total++; if (o_timeout !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL tmo_early tmo=%b busy=%b want=0,1", o_timeout, o_busy); end
    @(negedge clk);
    total++; if ({o_timeout, o_done, o_pass, o_busy} !== 4'b1100) begin bad++; $display("FAIL tmo_flags tmo,done,pass,busy got=%b want=1100", {o_timeout, o_done, o_pass, o_busy}); end
    total++; if (o_err_count !== EW'(1)) begin bad++; $display("FAIL tmo_err got=%0d want=1", o_err_count); end
    sent3 = 0;
    for (int c = 0; c < 30; c++) begin
      if (o_tx_data_valid !== 1'b0) sent3++;
      @(negedge clk);
    end
    total++; if (sent3 !== 0) begin bad++; $display("FAIL tmo_no_third_byte valid_cycles=%0d want=0", sent3); end
  endtask

  task automatic test_unsolicited();
    logic [7:0] d;
    bit got;
    int n_err, seq_bad, n_sent;
    pulse_start();
    i_start         = 1'b1;
    i_rx_data       = 8'h33;
    i_rx_data_valid = 1'b1;
    @(negedge clk);
    i_start         = 1'b0;
    i_rx_data_valid = 1'b0;
    total++; if (o_err_count !== EW'(1)) begin bad++; $display("FAIL unsol_send_err got=%0d want=1", o_err_count); end
    total++; if (o_tx_data_valid !== 1'b1 || o_tx_data !== model_byte(0)) begin bad++; $display("FAIL start_in_send valid=%b data=%h want=1,%h", o_tx_data_valid, o_tx_data, model_byte(0)); end
    xfer(0, d, got);
    pulse_start();
    echo(d, 10);
    run_model(1, 1'b0, -1, n_err, seq_bad, n_sent);
    total++; if (seq_bad !== 0 || n_sent !== int'(NB) - 1) begin bad++; $display("FAIL start_in_wait bad_bytes=%0d sent=%0d want=0,%0d", seq_bad, n_sent, NB - 1); end
    total++; if (o_done !== 1'b1 || o_pass !== 1'b0 || o_err_count !== EW'(1)) begin bad++; $display("FAIL unsol_final done=%b pass=%b err=%0d want=1,0,1", o_done, o_pass, o_err_count); end
    pulse_rx(8'h44);
    total++; if (o_err_count !== EW'(1) || o_done !== 1'b1) begin bad++; $display("FAIL done_stray_rx err=%0d done=%b want=1,1", o_err_count, o_done); end
  endtask

  task automatic test_reset_midrun();
    logic [7:0] d;
    bit got;
    int n_err, seq_bad, n_sent;
    pulse_start();
    pulse_rx(8'h77);
    xfer(0, d, got);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if ({o_tx_data, o_tx_data_valid, o_busy, o_done, o_pass, o_timeout} !== 13'd0 || o_err_count !== EW'(0)) begin
      bad++; $display("FAIL midrun_reset data=%h valid=%b busy=%b done=%b pass=%b tmo=%b err=%0d want all 0", o_tx_data, o_tx_data_valid, o_busy, o_done, o_pass, o_timeout, o_err_count);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    total++; if (o_tx_data !== model_byte(0) || o_err_count !== EW'(0)) begin bad++; $display("FAIL after_reset_start data=%h err=%0d want=%h,0", o_tx_data, o_err_count, model_byte(0)); end
    run_model(0, 1'b0, -1, n_err, seq_bad, n_sent);
    total++; if (o_pass !== 1'b1 || seq_bad !== 0 || n_sent !== int'(NB)) begin bad++; $display("FAIL after_reset_run pass=%b bad_bytes=%0d sent=%0d want=1,0,%0d", o_pass, seq_bad, n_sent, NB); end
  endtask

  task automatic test_saturate();
    int n_err, seq_bad, n_sent;
    pulse_start();
    pulse_rx(8'h00);
    run_model(0, 1'b0, -2, n_err, seq_bad, n_sent);
    total++; if (o_err_count !== EW'(sat(1 + n_err))) begin bad++; $display("FAIL saturate err got=%0d want=%0d", o_err_count, sat(1 + n_err)); end
    total++; if (o_pass !== 1'b0 || o_done !== 1'b1) begin bad++; $display("FAIL saturate_flags pass=%b done=%b want=0,1", o_pass, o_done); end
  endtask

  task automatic test_back_to_back();
    int n_err, seq_bad, n_sent;
    for (int r = 0; r < 6; r++) begin
      pulse_start();
      total++; if (o_done !== 1'b0 || o_busy !== 1'b1 || o_pass !== 1'b0) begin bad++; $display("FAIL b2b_restart run=%0d done=%b busy=%b pass=%b want=0,1,0", r, o_done, o_busy, o_pass); end
      run_model(0, 1'b1, -1, n_err, seq_bad, n_sent);
      total++; if (seq_bad !== 0 || n_sent !== int'(NB)) begin bad++; $display("FAIL b2b_sequence run=%0d bad_bytes=%0d sent=%0d want=0,%0d", r, seq_bad, n_sent, NB); end
      total++; if (o_err_count !== EW'(sat(n_err))) begin bad++; $display("FAIL b2b_err run=%0d got=%0d want=%0d", r, o_err_count, sat(n_err)); end
      total++; if (o_pass !== (n_err == 0) || o_done !== 1'b1) begin bad++; $display("FAIL b2b_pass run=%0d pass=%b done=%b want=%b,1", r, o_pass, o_done, (n_err == 0)); end
    end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    reset           = 1'b1;
    i_start         = 1'b0;
    i_tx_ready      = 1'b0;
    i_rx_data       = 8'h00;
    i_rx_data_valid = 1'b0;
    test_reset();
    test_ideal();
    test_corrupt();
    test_ready_stall();
    test_timeout();
    test_unsolicited();
    test_reset_midrun();
    test_saturate();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
